// File: rtl/ram_pkg.sv
// Shared types and default widths for the dual-port clearable RAM.
// Pure declarations: no latency or flow control lives here.
package ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram_core.sv
// Storage array with one synchronous write port and a registered, write-first read port.
// Read data lands one edge after rd_en; no backpressure, every enabled access is taken.
module ram_core
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself is never reset; only the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with a hardware clear sweep (DEPTH edges) after reset or on clear_req.
// Reads return one edge later with data_valid; while busy, all requests are dropped, not queued.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              clear_req,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clearing;
  logic              wr_acc;
  logic              rd_acc;
  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;

  assign clearing = (state == ST_CLEAR);
  assign busy     = clearing;

  // A clear request wins over any access presented in the same cycle.
  assign wr_acc = !clearing && !clear_req && write_enable;
  assign rd_acc = !clearing && !clear_req && read_enable;

  assign core_we    = clearing || wr_acc;
  assign core_waddr = clearing ? clr_cnt : wr_addr;
  assign core_wdata = clearing ? '0 : data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt    <= '0;
      data_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          data_valid <= rd_acc;
          if (clear_req) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          data_valid <= 1'b0;
          if (clr_cnt == LAST_ADDR) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (core_we),
    .wr_addr(core_waddr),
    .wr_data(core_wdata),
    .rd_en  (rd_acc),
    .rd_addr(rd_addr),
    .rd_data(data_out)
  );

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr: a word-array model predicts reads, a monitor checks every cycle.
module tb_ram_dp_clr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write_enable = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] data_in = '0;
  logic       read_enable = 1'b0;
  logic [3:0] rd_addr = '0;
  logic       clear_req = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;

  always #5 clk = ~clk;

  ram_dp_clr dut (
    .clk         (clk),
    .rst         (rst),
    .write_enable(write_enable),
    .wr_addr     (wr_addr),
    .data_in     (data_in),
    .read_enable (read_enable),
    .rd_addr     (rd_addr),
    .clear_req   (clear_req),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy)
  );

  typedef struct {
    int         cyc;
    logic [7:0] dat;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model_mem [16];
  int         clear_left = 0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        sb_q.delete();
        last_dat = '0;
        chk("reset_valid", {31'b0, data_valid}, 32'd0);
        chk("reset_data", {24'b0, data_out}, 32'd0);
      end else if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        chk("rd_valid", {31'b0, data_valid}, 32'd1);
        chk("rd_data", {24'b0, data_out}, {24'b0, sb_q[0].dat});
        last_dat = sb_q[0].dat;
        void'(sb_q.pop_front());
      end else begin
        chk("idle_valid", {31'b0, data_valid}, 32'd0);
        chk("hold_data", {24'b0, data_out}, {24'b0, last_dat});
      end
    end
  end

  // Reference: a sweep is modelled as an instant zeroing plus 16 dead edges.
  task automatic start_clear();
    foreach (model_mem[i]) model_mem[i] = 8'h00;
    clear_left = 16;
  endtask

  // Called at a falling edge; drives one cycle of requests and advances to the next falling edge.
  task automatic step(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                      input logic re, input logic [3:0] ra, input logic clr);
    chk("busy", {31'b0, busy}, {31'b0, (clear_left > 0)});
    write_enable = we; wr_addr = wa; data_in = wd;
    read_enable = re; rd_addr = ra; clear_req = clr;
    if (clear_left > 0) begin
      clear_left--;
    end else if (clr) begin
      start_clear();
    end else begin
      if (re) sb_q.push_back('{cyc: cyc + 1, dat: (we && wa == ra) ? wd : model_mem[ra]});
      if (we) model_mem[wa] = wd;
    end
    @(negedge clk);
    write_enable = 1'b0; read_enable = 1'b0; clear_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    chk("rst_now_data", {24'b0, data_out}, 32'd0);
    chk("rst_now_valid", {31'b0, data_valid}, 32'd0);
    repeat (n) @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    start_clear();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: bench did not complete, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset(2);

    // Auto-clear: busy for 16 edges, then every word reads zero.
    idle(16);
    for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'd0, 1'b1, 4'(a), 1'b0);
    idle(1);

    // Plain write then read, then an idle cycle.
    step(1'b1, 4'd1, 8'hAA, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 1'b0);
    idle(1);

    // Same-address bypass, and a different-address pair.
    step(1'b1, 4'd2, 8'h22, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd3, 8'h5C, 1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd4, 8'h44, 1'b1, 4'd2, 1'b0);
    idle(1);

    // Fill, then clear with a colliding write that must be dropped.
    for (int a = 0; a < 16; a++) step(1'b1, 4'(a), 8'(8'h10 + a), 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd7, 8'hFF, 1'b1, 4'd7, 1'b1);
    // Requests while busy are dropped.
    step(1'b1, 4'd9, 8'h77, 1'b1, 4'd9, 1'b0);
    idle(15);
    for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'd0, 1'b1, 4'(a), 1'b0);

    // Reset in the middle of a sweep restarts it from scratch.
    step(1'b1, 4'd5, 8'h55, 1'b1, 4'd5, 1'b0);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    idle(5);
    do_reset(2);
    idle(16);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ($urandom_range(0, 59) == 0));
    end
    idle(18);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
